// File: rtl/r4k_mem_arbiter.sv
// Arbitrates instruction fetches and data accesses onto one shared memory port, one access at a time.
// Define R4K_ARB_RR_EN for round-robin arbitration; default build gives data fixed priority.
module r4k_mem_arbiter #(
    parameter int unsigned MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_read,
    input  logic [63:0] instr_address,
    output logic [31:0] instr_in,
    output logic        instr_ready,
    input  logic        data_read,
    input  logic        data_write,
    input  logic [63:0] data_address,
    input  logic [63:0] data_out,
    input  logic [7:0]  data_mask,
    output logic [63:0] data_in,
    output logic        data_ready,
    output logic [63:0] mem_address,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_mask,
    output logic        mem_read,
    output logic        mem_write,
    input  logic [63:0] mem_rdata,
    input  logic        mem_ready,
    output logic        bus_error,
    output logic [1:0]  dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT_I = 2'd1,
        GRANT_D = 2'd2
    } state_t;

    localparam logic [15:0] MAX_WAIT_W = 16'(MAX_WAIT);

    state_t      state_q, state_d;
    logic        last_d_q, last_d_d;
    logic [63:0] addr_q, addr_d;
    logic [63:0] wdata_q, wdata_d;
    logic [7:0]  mask_q, mask_d;
    logic        write_q, write_d;
    logic [15:0] wait_q, wait_d;

    logic req_i, req_d, pick_d, busy, timeout, done, strobe_en;

    assign req_i = instr_read;
    assign req_d = data_read | data_write;

`ifdef R4K_ARB_RR_EN
    // On a tie, the requester that did not win last time gets the bus.
    assign pick_d = req_d && (!req_i || !last_d_q);
`else
    assign pick_d = req_d;
`endif

    assign busy      = (state_q != IDLE);
    // A response arriving in the timeout cycle wins: it is a normal completion.
    assign timeout   = busy && !mem_ready && (wait_q == MAX_WAIT_W);
    assign done      = busy && (mem_ready || timeout);
    assign strobe_en = busy && !timeout;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            last_d_q <= 1'b0;
            addr_q   <= 64'h0;
            wdata_q  <= 64'h0;
            mask_q   <= 8'h0;
            write_q  <= 1'b0;
            wait_q   <= 16'h0;
        end else begin
            state_q  <= state_d;
            last_d_q <= last_d_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            mask_q   <= mask_d;
            write_q  <= write_d;
            wait_q   <= wait_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        last_d_d = last_d_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        write_d  = write_q;
        wait_d   = wait_q;
        case (state_q)
            IDLE: begin
                if (req_i || req_d) begin
                    wait_d = 16'h0;
                    if (pick_d) begin
                        state_d  = GRANT_D;
                        last_d_d = 1'b1;
                        addr_d   = data_address;
                        wdata_d  = data_out;
                        mask_d   = data_mask;
                        write_d  = data_write;
                    end else begin
                        state_d  = GRANT_I;
                        last_d_d = 1'b0;
                        addr_d   = instr_address;
                        wdata_d  = 64'h0;
                        mask_d   = instr_address[2] ? 8'hF0 : 8'h0F;
                        write_d  = 1'b0;
                    end
                end
            end
            default: begin
                if (done) begin
                    state_d = IDLE;
                end else begin
                    wait_d = wait_q + 16'h1;
                end
            end
        endcase
    end

    assign mem_read    = strobe_en && !write_q;
    assign mem_write   = strobe_en && write_q;
    assign mem_address = busy ? addr_q : 64'h0;
    assign mem_wdata   = busy ? wdata_q : 64'h0;
    assign mem_mask    = busy ? mask_q : 8'h0;

    assign instr_ready = (state_q == GRANT_I) && done;
    assign data_ready  = (state_q == GRANT_D) && done;
    assign bus_error   = timeout;

    // Timed-out completions return zero data.
    assign instr_in = (instr_ready && mem_ready) ? (addr_q[2] ? mem_rdata[63:32] : mem_rdata[31:0]) : 32'h0;
    assign data_in  = (data_ready && mem_ready) ? mem_rdata : 64'h0;

    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_r4k_mem_arbiter.sv
// Scoreboard bench for r4k_mem_arbiter: expected memory-port accesses and completions are queued
// by the driver tasks and popped by an independent monitor.
module tb_r4k_mem_arbiter;
    localparam int MAXW = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_read = 1'b0;
    logic [63:0] instr_address = 64'h0;
    logic [31:0] instr_in;
    logic        instr_ready;
    logic        data_read = 1'b0;
    logic        data_write = 1'b0;
    logic [63:0] data_address = 64'h0;
    logic [63:0] data_out = 64'h0;
    logic [7:0]  data_mask = 8'h0;
    logic [63:0] data_in;
    logic        data_ready;
    logic [63:0] mem_address;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_mask;
    logic        mem_read;
    logic        mem_write;
    logic [63:0] mem_rdata = 64'h0;
    logic        mem_ready = 1'b0;
    logic        bus_error;
    logic [1:0]  dbg_state;

    r4k_mem_arbiter #(.MAX_WAIT(MAXW)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_read   (instr_read),
        .instr_address(instr_address),
        .instr_in     (instr_in),
        .instr_ready  (instr_ready),
        .data_read    (data_read),
        .data_write   (data_write),
        .data_address (data_address),
        .data_out     (data_out),
        .data_mask    (data_mask),
        .data_in      (data_in),
        .data_ready   (data_ready),
        .mem_address  (mem_address),
        .mem_wdata    (mem_wdata),
        .mem_mask     (mem_mask),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_rdata    (mem_rdata),
        .mem_ready    (mem_ready),
        .bus_error    (bus_error),
        .dbg_state_o  (dbg_state)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    logic [65:0]  rsp_q[$];   // {is_data, bus_error, data}
    logic [137:0] mem_q[$];   // {rd, wr, addr, wdata (writes only), mask}
    int           resp_lat = -1;
    logic [63:0]  resp_data = 64'h0;

    task automatic chk(input string name, input logic [137:0] act, input logic [137:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic exp_mem(input logic rd, input logic wr, input logic [63:0] a,
                           input logic [63:0] wd, input logic [7:0] m);
        mem_q.push_back({rd, wr, a, (wr ? wd : 64'h0), m});
    endtask

    task automatic exp_rsp(input logic is_d, input logic err, input logic [63:0] d);
        rsp_q.push_back({is_d, err, d});
    endtask

    // Memory responder: raises mem_ready for one cycle, resp_lat cycles into an access (-1 = never).
    initial begin
        bit active;
        int scnt;
        active = 0;
        scnt = 0;
        forever begin
            @(negedge clk);
            if (reset) begin
                active = 0;
                mem_ready = 1'b0;
                mem_rdata = 64'h0;
            end else if (mem_ready) begin
                mem_ready = 1'b0;
                mem_rdata = 64'h0;
                active = 0;
            end else begin
                if (!active && (mem_read || mem_write)) begin
                    active = 1;
                    scnt = 0;
                end
                if (active) begin
                    if (resp_lat >= 0 && scnt == resp_lat) begin
                        mem_ready = 1'b1;
                        mem_rdata = resp_data;
                    end else if (instr_ready || data_ready) begin
                        active = 0;
                    end else begin
                        scnt++;
                    end
                end
            end
        end
    end

    // Monitor: checks every completion and every new memory access against the queues.
    initial begin
        logic        strobe;
        logic        prev_strobe;
        logic [65:0] a_rsp;
        logic [137:0] a_mem;
        prev_strobe = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            strobe = mem_read | mem_write;
            if (!reset) begin
                if (instr_ready || data_ready || bus_error) begin
                    a_rsp = {data_ready, bus_error, (data_ready ? data_in : {32'h0, instr_in})};
                    if (rsp_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_resp: got %h, expected none", a_rsp);
                    end else begin
                        chk("resp", a_rsp, rsp_q.pop_front());
                    end
                end
                if (strobe && !prev_strobe) begin
                    a_mem = {mem_read, mem_write, mem_address, (mem_write ? mem_wdata : 64'h0), mem_mask};
                    if (mem_q.size() == 0) begin
                        n_cmp++;
                        n_fail++;
                        $display("FAIL unexpected_access: got %h, expected none", a_mem);
                    end else begin
                        chk("mem_access", a_mem, mem_q.pop_front());
                    end
                end
            end
            prev_strobe = strobe;
        end
    end

    task automatic wait_ready(input string name);
        int c;
        c = 0;
        while (!(instr_ready || data_ready) && c < 50) begin
            @(negedge clk);
            #1;
            c++;
        end
        if (!(instr_ready || data_ready)) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_no_ready: got no ready in %0d cycles, expected a ready pulse", name, c);
        end
    endtask

    task automatic do_fetch(input string name, input logic [63:0] addr, input int lat,
                            input logic [63:0] rd, input logic [7:0] e_mask,
                            input logic [31:0] e_word, input bit drop_early);
        @(negedge clk);
        #1;
        resp_lat = lat;
        resp_data = rd;
        exp_mem(1'b1, 1'b0, addr, 64'h0, e_mask);
        exp_rsp(1'b0, 1'b0, {32'h0, e_word});
        instr_address = addr;
        instr_read = 1'b1;
        @(negedge clk);
        #1;
        chk({name, "_strobe"}, {mem_read, mem_write}, 2'b10);
        if (drop_early) begin
            instr_read = 1'b0;
            instr_address = 64'hFFFF_FFF0;
        end
        wait_ready(name);
        if (drop_early) chk({name, "_addr_hold"}, mem_address, addr);
        instr_read = 1'b0;
    endtask

    task automatic do_data(input string name, input logic rd, input logic wr,
                           input logic [63:0] addr, input logic [63:0] wd, input logic [7:0] m,
                           input int lat, input logic [63:0] rdata,
                           input logic e_rd, input logic e_wr);
        @(negedge clk);
        #1;
        resp_lat = lat;
        resp_data = rdata;
        exp_mem(e_rd, e_wr, addr, wd, m);
        exp_rsp(1'b1, 1'b0, rdata);
        data_read = rd;
        data_write = wr;
        data_address = addr;
        data_out = wd;
        data_mask = m;
        @(negedge clk);
        #1;
        chk({name, "_strobe"}, {mem_read, mem_write}, {e_rd, e_wr});
        wait_ready(name);
        chk({name, "_instr_quiet"}, instr_ready, 1'b0);
        data_read = 1'b0;
        data_write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int c;
        logic [3:0] order;

        #1 reset = 1'b1;
        #1;
        chk("rst_strobes", {mem_read, mem_write}, 2'b00);
        chk("rst_readies", {instr_ready, data_ready, bus_error}, 3'b000);
        chk("rst_mem_port", {mem_address, mem_wdata, mem_mask}, 136'h0);
        chk("rst_data", {instr_in, data_in}, 96'h0);
        chk("rst_state", dbg_state, 2'd0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b0;

        do_fetch("fetch_0x4", 64'h4, 2, 64'h1111_2222_3333_4444, 8'hF0, 32'h1111_2222, 1'b0);
        do_data("store_0x100", 1'b0, 1'b1, 64'h100, 64'hDEAD, 8'h03, 0, 64'h0, 1'b0, 1'b1);
        do_data("rdwr_is_write", 1'b1, 1'b1, 64'h108, 64'h0123_4567_89AB_CDEF, 8'hFF, 1,
                64'h0, 1'b0, 1'b1);
        do_data("load_0x200", 1'b1, 1'b0, 64'h200, 64'h0, 8'hFF, 3,
                64'h5555_6666_7777_8888, 1'b1, 1'b0);
        do_fetch("fetch_drop", 64'h8, 2, 64'h9999_AAAA_BBBB_CCCC, 8'h0F, 32'hBBBB_CCCC, 1'b1);

        // A request withdrawn before the clock edge must never be granted.
        @(negedge clk);
        #1;
        instr_address = 64'h40;
        instr_read = 1'b1;
        #3 instr_read = 1'b0;
        @(negedge clk);
        #1;
        chk("pregrant_drop_strobe", {mem_read, mem_write}, 2'b00);
        chk("pregrant_drop_state", dbg_state, 2'd0);

        // Timeout with MAX_WAIT=4: four strobe cycles, then ready+bus_error with zero data.
        @(negedge clk);
        #1;
        resp_lat = -1;
        exp_mem(1'b1, 1'b0, 64'h300, 64'h0, 8'hFF);
        exp_rsp(1'b1, 1'b1, 64'h0);
        data_address = 64'h300;
        data_mask = 8'hFF;
        data_out = 64'h0;
        data_read = 1'b1;
        cnt = 0;
        c = 0;
        while (c < 20) begin
            @(negedge clk);
            #1;
            c++;
            if (data_ready || instr_ready) break;
            if (mem_read) cnt++;
        end
        chk("timeout_ready", {data_ready, bus_error}, 2'b11);
        chk("timeout_strobe_cycles", cnt, MAXW);
        chk("timeout_strobe_drop", {mem_read, mem_write}, 2'b00);
        data_read = 1'b0;
        @(negedge clk);
        #1;
        chk("timeout_then_idle", {dbg_state, bus_error, data_ready}, 4'b0000);

        // mem_ready landing exactly in the timeout cycle is a normal completion.
        do_fetch("coincide", 64'hC, 4, 64'hCAFE_F00D_1234_5678, 8'hF0, 32'hCAFE_F00D, 1'b0);

        // Reset in the second strobe cycle abandons the fetch; the held fetch is re-granted.
        @(negedge clk);
        #1;
        resp_lat = -1;
        exp_mem(1'b1, 1'b0, 64'h10, 64'h0, 8'h0F);
        instr_address = 64'h10;
        instr_read = 1'b1;
        @(negedge clk);
        #1;
        chk("rstmid_first_strobe", mem_read, 1'b1);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("rstmid_strobe_drop", {mem_read, mem_write}, 2'b00);
        chk("rstmid_no_ready", {instr_ready, data_ready, bus_error}, 3'b000);
        resp_lat = 1;
        resp_data = 64'h0BAD_0BAD_600D_600D;
        exp_mem(1'b1, 1'b0, 64'h10, 64'h0, 8'h0F);
        exp_rsp(1'b0, 1'b0, 64'h600D_600D);
        @(negedge clk);
        #1;
        reset = 1'b0;
        chk("rstmid_no_early_grant", mem_read, 1'b0);
        @(negedge clk);
        #1;
        chk("rstmid_regrant", mem_read, 1'b1);
        wait_ready("rstmid");
        instr_read = 1'b0;

        // Both requesters held for four accesses; bit k set means access k goes to the fetch.
`ifdef R4K_ARB_RR_EN
        order = 4'b1010;
`else
        order = 4'b0000;
`endif
        @(negedge clk);
        #1;
        resp_lat = 1;
        resp_data = 64'hAAAA_BBBB_CCCC_DDDD;
        for (int k = 0; k < 4; k++) begin
            if (order[k]) begin
                exp_mem(1'b1, 1'b0, 64'h8, 64'h0, 8'h0F);
                exp_rsp(1'b0, 1'b0, 64'hCCCC_DDDD);
            end else begin
                exp_mem(1'b1, 1'b0, 64'h200, 64'h0, 8'hFF);
                exp_rsp(1'b1, 1'b0, 64'hAAAA_BBBB_CCCC_DDDD);
            end
        end
        instr_address = 64'h8;
        data_address = 64'h200;
        data_mask = 8'hFF;
        data_out = 64'h0;
        data_read = 1'b1;
        instr_read = 1'b1;
        cnt = 0;
        c = 0;
        while (cnt < 4 && c < 100) begin
            @(negedge clk);
            #1;
            c++;
            if (instr_ready || data_ready) cnt++;
        end
        data_read = 1'b0;
        instr_read = 1'b0;
        chk("arb_completions", cnt, 4);

        repeat (4) @(negedge clk);
        #2;
        chk("rsp_queue_drained", rsp_q.size(), 0);
        chk("mem_queue_drained", mem_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
